// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit next to the combinational ALU.
// A start pulse in IDLE captures op, a and b. MUL/UMULL/SMULL use a shift-add
// loop and DIV uses a restoring loop, each running WIDTH cycles. One fix-up
// cycle follows, then done pulses for one cycle.
// Ports:
//   clk, reset (async, active-low)
//   start, op[3:0], a, b                  request (start sampled only in IDLE)
//   busy                                  high while iterating
//   done                                  one-cycle result-valid pulse
//   result_lo, result_hi                  product words / quotient, remainder
//   dz, err                               divide-by-zero / unsupported op flags
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             dz,
  output logic             err
);

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b0111;

  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Unsigned magnitude of a two's-complement value. The most negative value
  // maps to itself, which reads correctly as the unsigned value 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + ONE_W) : x;
  endfunction

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand or divisor
  logic [WIDTH-1:0]   p_q, p_d;           // product high half / remainder
  logic [WIDTH-1:0]   q_q, q_d;           // multiplier low half / quotient
  logic               sign_q, sign_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               dz_q, dz_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_sh_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_neg_s;

  // Datapath for one iteration step and the final sign fix-up.
  always_comb begin
    mul_sum_s  = {1'b0, p_q} + (q_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    div_sh_s   = {p_q, q_q[WIDTH-1]};
    div_ge_s   = (div_sh_s >= {1'b0, mcand_q});
    // The difference always fits in WIDTH bits because it is below the divisor.
    div_diff_s = div_sh_s[WIDTH-1:0] - mcand_q;
    prod_s     = {p_q, q_q};
    prod_neg_s = ~prod_s + ONE_2W;
  end

  // Next-state and next-output logic for the control FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    q_d     = q_q;
    sign_d  = sign_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dz_d    = dz_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          dz_d  = 1'b0;
          err_d = 1'b0;
          cnt_d = {CW{1'b0}};
          p_d   = {WIDTH{1'b0}};
          case (op)
            OP_MUL, OP_UMULL: begin
              mcand_d = a;
              q_d     = b;
              sign_d  = 1'b0;
              state_d = S_CALC;
              busy_d  = 1'b1;
            end
            OP_SMULL: begin
              mcand_d = mag(a);
              q_d     = mag(b);
              sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
              state_d = S_CALC;
              busy_d  = 1'b1;
            end
            OP_DIV: begin
              if (b == {WIDTH{1'b0}}) begin
                lo_d    = {WIDTH{1'b1}};
                hi_d    = a;
                dz_d    = 1'b1;
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                mcand_d = b;
                q_d     = a;
                sign_d  = 1'b0;
                state_d = S_CALC;
                busy_d  = 1'b1;
              end
            end
            default: begin
              lo_d    = {WIDTH{1'b0}};
              hi_d    = {WIDTH{1'b0}};
              err_d   = 1'b1;
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (op_q == OP_DIV) begin
          p_d = div_ge_s ? div_diff_s : div_sh_s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], div_ge_s};
        end else begin
          p_d = mul_sum_s[WIDTH:1];
          q_d = {mul_sum_s[0], q_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_FIX;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          busy_d  = 1'b1;
        end
      end

      S_FIX: begin
        case (op_q)
          OP_MUL: begin
            hi_d = {WIDTH{1'b0}};
            lo_d = q_q;
          end
          OP_SMULL: begin
            {hi_d, lo_d} = sign_q ? prod_neg_s : prod_s;
          end
          OP_DIV: begin
            lo_d = q_q;
            hi_d = p_q;
          end
          default: begin
            {hi_d, lo_d} = prod_s;
          end
        endcase
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= 4'b0000;
      mcand_q <= {WIDTH{1'b0}};
      p_q     <= {WIDTH{1'b0}};
      q_q     <= {WIDTH{1'b0}};
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      q_q     <= q_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign dz        = dz_q;
  assign err       = err_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=32).
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        dz;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq #(.WIDTH(32), .CW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .dz        (dz),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one start pulse and check latency, busy duration, results and hold.
  task automatic run_op(input string tag, input logic [3:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] lo_e, input logic [31:0] hi_e,
                        input logic dz_e, input logic err_e);
    int cyc;
    int busy_cnt;
    int lat_e;
    lat_e = (dz_e || err_e) ? 1 : 34;
    @(negedge clk);
    start = 1'b1;
    op = op_i;
    a = a_i;
    b = b_i;
    @(negedge clk);
    start = 1'b0;
    // Scramble operands: the DUT must use the values captured at start.
    op = 4'($urandom_range(0, 15));
    a = $urandom;
    b = $urandom;
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat_e));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'((lat_e == 1) ? 0 : 32));
    check({tag, "_result"}, {result_hi, result_lo}, {hi_e, lo_e});
    check({tag, "_flags"}, {62'd0, dz, err}, {62'd0, dz_e, err_e});
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_hold"}, {result_hi, result_lo}, {hi_e, lo_e});
  endtask

  initial begin
    int dones;
    reset = 1'b0;
    start = 1'b0;
    op = 4'b0000;
    a = 32'd0;
    b = 32'd0;

    vecs[0]  = '{4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2]  = '{4'b0100, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'h00000000, 1'b0, 1'b0};
    vecs[3]  = '{4'b0111, 32'd100,      32'd7,        32'd14,        32'd2,        1'b0, 1'b0};
    vecs[4]  = '{4'b0111, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0};
    vecs[5]  = '{4'b0010, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    vecs[6]  = '{4'b0100, 32'd3,        32'd5,        32'd15,        32'd0,        1'b0, 1'b0};
    vecs[7]  = '{4'b0110, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0};
    vecs[8]  = '{4'b0110, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b0, 1'b0};
    vecs[9]  = '{4'b0101, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0, 1'b0};
    vecs[10] = '{4'b0111, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0};
    vecs[11] = '{4'b0111, 32'd7,        32'd100,      32'd0,         32'd7,        1'b0, 1'b0};
    vecs[12] = '{4'b0110, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[13] = '{4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,         32'd0,        1'b0, 1'b0};
    vecs[14] = '{4'b0111, 32'h80000000, 32'd3,        32'h2AAAAAAA, 32'd2,        1'b0, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", {28'd0, busy, done, dz, err, result_hi}, 64'd0);
    check("reset_lo", {32'd0, result_lo}, 64'd0);
    reset = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].lo, vecs[i].hi, vecs[i].dz, vecs[i].err);
    end

    // Start held high with operands changing; second start in DONE ignored.
    @(negedge clk);
    start = 1'b1;
    op = 4'b0101;
    a = 32'd3;
    b = 32'd5;
    dones = 0;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (done) dones++;
      a = $urandom;
      b = $urandom;
      if (i == 34) start = 1'b0;
    end
    check("held_start_result", {result_hi, result_lo}, 64'd15);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("held_start_done_count", 64'(dones), 64'd1);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start = 1'b1;
    op = 4'b0111;
    a = 32'd100;
    b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", {63'd0, busy}, 64'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_outputs", {28'd0, busy, done, dz, err, result_hi}, 64'd0);
    check("abort_lo", {32'd0, result_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run_op("after_reset", 4'b0111, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multi-cycle execution unit on the responder side of the decoder's multiply/divide controls.
- Accepts an ALUControl code (MUL 0100, UMULL 0101, SMULL 0110, DIV 0111) plus operands via a start pulse.
- Computes over WIDTH cycles with shift-add or restoring division, then returns a 64-bit result with a one-cycle done pulse.
- Sits beside the combinational ALU in the datapath. The main FSM holds in an execute state until done.

Parameters:
- WIDTH, 32, operand width; result_lo and result_hi are each WIDTH bits.
- CW, 6, iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  4  ALUControl code: 0100 MUL, 0101 UMULL, 0110 SMULL, 0111 DIV
- a  input  WIDTH  operand Rn (multiplicand or dividend)
- b  input  WIDTH  operand Rm (multiplier or divisor)
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse when results are valid
- result_lo  output  WIDTH  MUL/UMULL/SMULL low word; DIV quotient
- result_hi  output  WIDTH  UMULL/SMULL high word; DIV remainder; 0 for MUL
- dz  output  1  divide-by-zero flag for the last DIV; held with the results
- err  output  1  last accepted op was unsupported; held with the results

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, all internal registers=0.
  - busy=0, done=0, result_lo=0, result_hi=0, dz=0, err=0.
  - Reset during CALC aborts the operation. No done pulse is produced.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, latch op, a and b.
  - Supported op with b!=0 or non-DIV: go to CALC, counter=0.
  - DIV with b=0: go to DONE with result_lo=all ones, result_hi=a, dz=1.
  - Unsupported op: go to DONE with results=0, err=1.
  - dz and err are cleared on every accepted start that does not set them.
- CALC:
  - busy=1. Executes one iteration per cycle for exactly WIDTH cycles (counter 0..WIDTH-1), then goes to FIX.
- Multiply iteration (2*WIDTH accumulator {P,Q}):
  - Q is initialised to the multiplier, P to 0.
  - If Q[0]=1, P=P+multiplicand with carry.
  - Then shift {carry,P,Q} right by one.
  - SMULL operates on magnitudes |a| and |b|. The sign is recorded as a[WIDTH-1]^b[WIDTH-1].
- Divide iteration (restoring, unsigned):
  - Shift {R,Q} left by one.
  - If R>=b, then R=R-b and Q[0]=1.
- FIX (one cycle):
  - SMULL with sign=1: two's-complement negate the 2*WIDTH product.
  - Write result registers:
    - MUL: hi=0, lo=product[WIDTH-1:0].
    - UMULL/SMULL: {hi,lo}=product.
    - DIV: lo=Q, hi=R.
  - Go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then return to IDLE.
  - Results, dz and err hold until the next accepted start writes them.
- Latency from the start edge:
  - Normal ops: done is high on the cycle after start plus WIDTH+1 cycles (CALC plus FIX), i.e. 34 cycles after start for WIDTH=32.
  - Divide-by-zero and unsupported ops: done is high 1 cycle after start.
- start is ignored in CALC, FIX and DONE. It is not queued.
- Operands are captured at start. Changes to a, b or op afterwards have no effect.
- Arithmetic edge cases:
  - SMULL of the most negative value (0x80000000 * 0x80000000) yields 0x4000000000000000.
  - The magnitude of 0x80000000 is treated as unsigned 2^31.

Test Plan:
- UMULL: a=0xFFFFFFFF, b=0xFFFFFFFF, start pulse -> done exactly 34 cycles later, {hi,lo}=0xFFFFFFFE_00000001, busy high for cycles 1..32.
- SMULL: a=0xFFFFFFFE (-2), b=0x00000003 -> {hi,lo}=0xFFFFFFFF_FFFFFFFA. MUL on the same operands -> hi=0, lo=0xFFFFFFFA.
- DIV: a=100, b=7 -> lo=14, hi=2, dz=0. DIV with a=5, b=0 -> done 1 cycle after start, lo=0xFFFFFFFF, hi=5, dz=1.
- Unsupported op=0010 with start -> done next cycle, err=1, results 0. A following valid MUL clears err.
- Start held high and operands changed during CALC -> single done pulse, result matches the operands captured at start. A second start issued in DONE is ignored.
- Assert reset mid-CALC at cycle 10 -> all outputs 0 immediately (asynchronous), no done pulse. A fresh start after reset release completes normally.
